uart_tx_frame: RTL

Parameterized asynchronous-serial transmitter that consumes the one-cycle baud tick produced by the rate enable generator and serializes one parallel word per request onto `txd`. Frames are start bit, DATA_BITS data bits LSB-first, an optional parity bit, then STOP_BITS stop bits. On each accepted request it drives `baud_clr` back into the rate enable generator's `clr`, so every bit cell is exactly one tick period long. It sits between the link-layer byte source and the physical transmit pin.

---
 rtl/uart_tx_frame.sv | 123 ++++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// Asynchronous-serial transmitter driven by an external one-cycle baud tick.
// Frame: start bit, DATA_BITS data bits LSB-first, optional parity bit,
// STOP_BITS stop bits. Accepting a word pulses baud_clr so the rate
// generator restarts and every bit cell is exactly one tick period long.
module uart_tx_frame #(
    parameter int DATA_BITS = 8,  // 5..9
    parameter int PARITY    = 0,  // 0 = none, 1 = even, 2 = odd
    parameter int STOP_BITS = 1   // 1 or 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 baud_enb,
    output logic                 baud_clr,
    output logic                 txd,
    output logic                 rdy
);

    // Wide enough to hold DATA_BITS, so the counter never wraps inside a frame.
    localparam int               CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 par_bit;

    // Accept strobe doubles as the rate generator clear; held low during reset.
    assign baud_clr = send & rdy & ~rst;

    // Frame sequencer: one registered machine owns txd, rdy, shift register and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            rdy      <= 1'b1;
            // NOTE: the datapath is reset as well, so a frame aborted by reset leaves no stale bits behind.
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    rdy <= 1'b1;
                    if (send) begin
                        shreg    <= data;
                        par_bit  <= (PARITY == 2) ? ~(^data) : ^data;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        txd      <= 1'b0;
                        rdy      <= 1'b0;
                        state    <= START;
                    end
                end

                START: begin
                    if (baud_enb) begin
                        txd   <= shreg[0];
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (baud_enb) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY != 0) begin
                                txd   <= par_bit;
                                state <= PAR;
                            end else begin
                                txd   <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            // Next bit is the one that becomes shreg[0] after this shift.
                            txd <= shreg[1];
                        end
                    end
                end

                PAR: begin
                    if (baud_enb) begin
                        txd   <= 1'b1;
                        state <= STOP;
                    end
                end

                STOP: begin
                    if (baud_enb) begin
                        if (stop_cnt == STOP_LAST) begin
                            rdy   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end

                default: begin
                    txd   <= 1'b1;
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
